// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift_sched block: FSM state encoding and
// default geometry of the stage pipeline.
package shift_sched_pkg;

  localparam int SS_DATA_W = 8;
  localparam int SS_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from the requests,
// the enable and the registered last-grant pointer; the pointer moves only
// when a grant is actually issued.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // last_reg = index of the requester granted most recently (1 after reset
  // so requester 0 wins the first contention)
  logic last_reg;

  // pick the requester that was not served last when both are asking
  always_comb begin
    gnt0 = en & req0 & (~req1 | last_reg);
    gnt1 = en & req1 & (~req0 | ~last_reg);
  end

  // pointer update on grant only
  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg <= 1'b1;
    end else if (gnt0) begin
      last_reg <= 1'b0;
    end else if (gnt1) begin
      last_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Two-requester scheduler feeding a lock-step shift pipeline. Every stage
// advances together whenever the output stage is empty or being consumed;
// new bytes enter stage 0 from the round-robin arbiter. A small FSM tracks
// IDLE/ACTIVE/FLUSH; during FLUSH no new bytes are accepted while the
// pipeline drains naturally.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int DATA_W = SS_DATA_W,
  parameter int DEPTH  = SS_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [2:0]        occ,
  output logic              busy
);

  logic [DEPTH-1:0]  valid_reg;
  logic [DATA_W-1:0] data_reg [DEPTH];
  logic [DEPTH-1:0]  src_reg;
  state_t            state_reg;

  logic              adv;
  logic              arb_en;
  logic              grant;
  logic [DEPTH-1:0]  valid_next;
  logic [2:0]        occ_now;
  logic [2:0]        occ_next;

  function automatic logic [2:0] popcnt(input logic [DEPTH-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + 3'(v[i]);
    end
    return c;
  endfunction

  // advance/grant qualification and occupancy before and after this edge
  always_comb begin
    adv        = ~valid_reg[DEPTH-1] | out_ready;
    arb_en     = adv & (state_reg != FLUSH) & ~flush & ~reset;
    grant      = req0_ready | req1_ready;
    valid_next = adv ? {valid_reg[DEPTH-2:0], grant} : valid_reg;
    occ_now    = popcnt(valid_reg);
    occ_next   = popcnt(valid_next);
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req0  (req0_valid),
    .req1  (req1_valid),
    .gnt0  (req0_ready),
    .gnt1  (req1_ready)
  );

  // lock-step shift of all stages; stage 0 takes the granted byte or a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      src_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= '0;
      end
    end else if (adv) begin
      valid_reg <= valid_next;
      src_reg   <= {src_reg[DEPTH-2:0], req1_ready};
      for (int i = DEPTH - 1; i > 0; i--) begin
        data_reg[i] <= data_reg[i-1];
      end
      data_reg[0] <= req1_ready ? req1_data : (req0_ready ? req0_data : '0);
    end
  end

  // state tracking; leaving ACTIVE/FLUSH looks at the occupancy after this
  // edge so busy falls on the same edge the last byte leaves
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush) begin
            state_reg <= FLUSH;
          end else if (grant) begin
            state_reg <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (flush) begin
            state_reg <= FLUSH;
          end else if ((occ_next == 3'd0) && !grant) begin
            state_reg <= IDLE;
          end
        end
        FLUSH: begin
          if (occ_next == 3'd0) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // outputs come straight from the registers, forced quiet while in reset
  always_comb begin
    out_valid = valid_reg[DEPTH-1] & ~reset;
    out_data  = data_reg[DEPTH-1];
    out_src   = src_reg[DEPTH-1];
    occ       = reset ? 3'd0 : occ_now;
    busy      = (state_reg != IDLE) & ~reset;
  end

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: directed scenarios followed by random traffic,
// all checked against a behavioural model (slot array + FIFO scoreboard).
module tb_shift_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_ready;
  logic [2:0] occ;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // model: four slots, a last-grant index, a mode (0 idle,1 active,2 flush)
  int m_v [4];
  int m_d [4];
  int m_s [4];
  int m_last;
  int m_mode;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  shift_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .occ        (occ),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      $error("check %s did not match", tag);
    end
  endtask

  // one clock: drive, check mid-cycle, advance the model on the edge
  task automatic step(input bit r0v, input logic [7:0] r0d, input bit r1v,
                      input logic [7:0] r1d, input bit fl, input bit ordy,
                      input bit rst);
    int cnt, ncnt, adv, can, g0, g1, gr;
    logic [8:0] e;
    req0_valid = r0v; req0_data = r0d;
    req1_valid = r1v; req1_data = r1d;
    flush = fl; out_ready = ordy; reset = rst;
    #1;
    cnt = m_v[0] + m_v[1] + m_v[2] + m_v[3];
    adv = (m_v[3] == 0 || ordy) ? 1 : 0;
    can = (adv == 1 && m_mode != 2 && !fl && !rst) ? 1 : 0;
    g0  = (can == 1 && r0v && (!r1v || m_last == 1)) ? 1 : 0;
    g1  = (can == 1 && r1v && (!r0v || m_last == 0)) ? 1 : 0;
    gr  = g0 | g1;
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    chk("out_valid", 32'(out_valid), rst ? 32'd0 : 32'(m_v[3]));
    chk("occ", 32'(occ), rst ? 32'd0 : 32'(cnt));
    chk("busy", 32'(busy), (rst || m_mode == 0) ? 32'd0 : 32'd1);
    if (!rst && m_v[3] == 1) begin
      chk("out_data", 32'(out_data), 32'(m_d[3]));
      chk("out_src", 32'(out_src), 32'(m_s[3]));
      if (ordy) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("deliver_order", {23'd0, out_src, out_data}, {23'd0, e});
          $display("deliver src=%0d data=%02h t=%0t", out_src, out_data, $time);
        end
      end
    end
    if (g0 == 1) sb.push_back({1'b0, r0d});
    if (g1 == 1) sb.push_back({1'b1, r1d});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_v[i] = 0; m_d[i] = 0; m_s[i] = 0; end
      m_last = 1; m_mode = 0;
      sb.delete();
    end else begin
      if (adv == 1) begin
        for (int i = 3; i > 0; i--) begin
          m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; m_s[i] = m_s[i-1];
        end
        m_v[0] = gr;
        m_d[0] = g1 ? int'(r1d) : (g0 ? int'(r0d) : 0);
        m_s[0] = g1;
      end
      if (g0 == 1) m_last = 0;
      if (g1 == 1) m_last = 1;
      ncnt = m_v[0] + m_v[1] + m_v[2] + m_v[3];
      case (m_mode)
        0: if (fl) m_mode = 2; else if (gr == 1) m_mode = 1;
        1: if (fl) m_mode = 2; else if (ncnt == 0 && gr == 0) m_mode = 0;
        default: if (ncnt == 0) m_mode = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, 0, ordy, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin m_v[i] = 0; m_d[i] = 0; m_s[i] = 0; end
    m_last = 1; m_mode = 0;
    @(negedge clk);

    // reset, outputs must be quiet while it is held
    step(1, 8'h11, 1, 8'h22, 0, 1, 1);
    step(0, 8'h00, 0, 8'h00, 0, 1, 1);

    // single byte 0xA5 from requester 0, four-cycle latency
    step(1, 8'hA5, 0, 8'h00, 0, 1, 0);
    idle(6, 1);

    // contention: alternate 0,1,0,1
    for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i/2), 1, 8'h20 + 8'(i/2), 0, 1, 0);
    idle(6, 1);

    // backpressure: fill with out_ready low, hold three more cycles, release
    for (int i = 0; i < 7; i++) step(1, 8'h30 + 8'(i), 1, 8'h40 + 8'(i), 0, 0, 0);
    idle(6, 1);

    // flush with three bytes in flight and requester 1 pending
    for (int i = 0; i < 3; i++) step(1, 8'h50 + 8'(i), 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 8'h60, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 8'h61 + 8'(i), 0, 1, 0);
    idle(6, 1);

    // mid-operation reset with three bytes in flight, then contention
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 8'h70 + 8'(i), 0, 1, 0);
    step(1, 8'h7A, 1, 8'h7B, 0, 1, 1);
    for (int i = 0; i < 2; i++) step(1, 8'h80 + 8'(i), 1, 8'h90 + 8'(i), 0, 1, 0);
    idle(6, 1);

    // flush while idle and empty: one cycle of FLUSH
    idle(1, 1);
    step(0, 8'h00, 0, 8'h00, 1, 1, 0);
    idle(3, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 63) == 0));
    end
    idle(8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter DATA_W, default 8, width of each data byte and pipeline stage.
REQ-002 Parameter DEPTH, default 4, number of pipeline stages; fixed at 4 for this release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 offers a byte.
REQ-006 req0_data  input  DATA_W  requester 0 byte.
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-008 req1_valid / req1_data / req1_ready  same as REQ-005..007 for requester 1.
REQ-009 flush  input  1  single-cycle pulse: stop accepting, drain pipeline.
REQ-010 out_valid  output  1  stage DEPTH-1 holds a valid byte.
REQ-011 out_data  output  DATA_W  stage DEPTH-1 byte.
REQ-012 out_src  output  1  source requester of out_data (0 or 1).
REQ-013 out_ready  input  1  consumer accepts out_data this cycle.
REQ-014 occ  output  3  number of valid stages, 0..4.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Block SHALL hold DEPTH stages, each with valid bit, DATA_W data and 1-bit src tag; stage i feeds stage i+1.
REQ-017 adv = ~valid[DEPTH-1] | out_ready; when adv, all stages SHALL shift one place in the same cycle; when ~adv, all stages SHALL hold.
REQ-018 On adv, stage 0 SHALL load the granted byte with valid=1 and src=grant index, or load a bubble (valid=0) if no grant.
REQ-019 Grant SHALL be issued only when adv is high and state is not FLUSH; at most one reqN_ready high per cycle.
REQ-020 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-021 Last-grant pointer SHALL update only on a grant.
REQ-022 reqN_ready SHALL be combinational from reqN_valid, adv, state and pointer; reqN_ready SHALL never be high while reqN_valid is low.
REQ-023 Latency: a byte accepted in cycle t SHALL appear with out_valid in cycle t+4 if adv is high in cycles t+1..t+3; each stalled cycle adds one.
REQ-024 Stall: while out_valid=1 and out_ready=0, out_data/out_src SHALL hold stable and no grants SHALL occur.
REQ-025 occ SHALL equal the count of set stage valid bits after every edge.
REQ-026 FSM states IDLE, ACTIVE, FLUSH.
REQ-027 IDLE -> ACTIVE on a grant; IDLE -> FLUSH on flush.
REQ-028 ACTIVE -> IDLE when occ becomes 0 with no grant that cycle; ACTIVE -> FLUSH on flush.
REQ-029 FLUSH -> IDLE when occ is 0; pipeline keeps shifting under REQ-017 and all valid bytes SHALL be delivered, none dropped.
REQ-030 flush and a request in the same cycle: flush wins, no grant that cycle.
REQ-031 flush while already in FLUSH SHALL be ignored.
REQ-032 flush in IDLE with empty pipeline: FLUSH for exactly one cycle, then IDLE.

Reset
REQ-033 On reset, all stage valid bits, data and src SHALL clear to 0; state SHALL be IDLE; last-grant pointer SHALL be 1 (requester 0 wins first).
REQ-034 Reset SHALL override all other inputs in the same cycle; bytes in flight mid-operation SHALL be discarded.
REQ-035 While reset is high, req0_ready, req1_ready and out_valid SHALL be 0, occ SHALL be 0 and busy SHALL be 0.

Structure
REQ-036 Package shift_sched_pkg SHALL hold the state enumeration, DATA_W and DEPTH defaults.
REQ-037 Arbitration SHALL live in sub-module rr_arb2 (two requests, enable, grant outputs, registered pointer); the pipeline and FSM stay in shift_sched.

Verification
REQ-038 Single byte: req0 sends 0xA5 at cycle 1, out_ready=1 -> out_valid with 0xA5, src=0 at cycle 5; occ goes 1,1,1,1,0.
REQ-039 Contention: both valid continuously, req0=0x10.., req1=0x20.. -> grants alternate 0,1,0,1; outputs 0x10,0x20,0x11,0x21 with src 0,1,0,1.
REQ-040 Backpressure: pipeline full (occ=4), out_ready=0 for 3 cycles -> both readies 0, out_data stable, occ=4; release -> one byte per cycle.
REQ-041 Flush: 3 bytes in flight, pulse flush with req1_valid=1 -> no grant until IDLE; 3 bytes delivered; busy drops to 0 after the last one leaves.
REQ-042 Mid-operation reset: occ=3, reset for 1 cycle -> next cycle occ=0, out_valid=0, state IDLE; next contention grants req0 first.
REQ-043 Flush in IDLE: flush at cycle 2, no requests -> busy=1 for exactly cycle 3, busy=0 at cycle 4.
